// File: rtl/bsh_pkg.sv
// Shared definitions for the barrel-shifter arbiter slice.
//   - FSM state encoding for bsh_arb
//   - shift direction encoding used by bsh_32
//   - default data / shift-amount widths
package bsh_pkg;

  localparam int DW_DEF  = 32;
  localparam int SHW_DEF = 5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/bsh_32.sv
// 32-bit logical barrel shifter, purely combinational.
// Ports:
//   data_in  [31:0]  operand
//   dir              DIR_LEFT = logical left, DIR_RIGHT = logical right
//   sh       [4:0]   shift amount
//   data_out [31:0]  shifted result, zero filled
module bsh_32
  import bsh_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic        dir,
  input  logic [4:0]  sh,
  output logic [31:0] data_out
);

  assign data_out = (dir == DIR_RIGHT) ? (data_in >> sh) : (data_in << sh);

endmodule

// File: rtl/bsh_arb.sv
// Two-port round-robin arbiter/sequencer sharing one bsh_32 instance.
// A request is accepted in IDLE, shifted from registered operands in SHIFT,
// and the registered result is held for the owning port in RESP.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqX_valid/ready           request channel per port
//   reqX_data/dir/sh           operand, direction, shift amount
//   rspX_valid/ready           response channel per port
//   rsp_data                   shared registered result
//   busy                       high outside IDLE
//   done_cnt                   saturating count of completed responses
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for a request; combinational round-robin grant
// ST_SHIFT | shifter driven from operand registers, result captured
// ST_RESP  | result held for owner until its rsp_ready handshake
module bsh_arb
  import bsh_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int SHW  = SHW_DEF,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DW-1:0]   req0_data,
  input  logic            req0_dir,
  input  logic [SHW-1:0]  req0_sh,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DW-1:0]   req1_data,
  input  logic            req1_dir,
  input  logic [SHW-1:0]  req1_sh,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [DW-1:0]   rsp_data,
  output logic            busy,
  output logic [CNTW-1:0] done_cnt
);

  state_t           state, state_n;
  logic             ptr;      // port favoured when both request
  logic             owner;    // port whose operation is in flight
  logic [DW-1:0]    op_data;
  logic             op_dir;
  logic [SHW-1:0]   op_sh;
  logic [DW-1:0]    shift_out;
  logic             gnt0, gnt1, rsp_hs;

  always_comb begin
    state_n = state;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    rsp_hs  = 1'b0;
    case (state)
      ST_IDLE: begin
        // rst_n gating keeps ready low while reset is held even though
        // the grant is combinational from the live valids.
        gnt0 = rst_n & req0_valid & (~req1_valid | ~ptr);
        gnt1 = rst_n & req1_valid & (~req0_valid |  ptr);
        if (gnt0 | gnt1) state_n = ST_SHIFT;
      end
      ST_SHIFT: state_n = ST_RESP;
      ST_RESP: begin
        rsp_hs = owner ? rsp1_ready : rsp0_ready;
        if (rsp_hs) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = (state == ST_RESP) & ~owner;
  assign rsp1_valid = (state == ST_RESP) &  owner;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 1'b0;
      owner    <= 1'b0;
      op_data  <= '0;
      op_dir   <= 1'b0;
      op_sh    <= '0;
      rsp_data <= '0;
      done_cnt <= '0;
    end else begin
      if (gnt0) begin
        owner   <= 1'b0;
        op_data <= req0_data;
        op_dir  <= req0_dir;
        op_sh   <= req0_sh;
      end else if (gnt1) begin
        owner   <= 1'b1;
        op_data <= req1_data;
        op_dir  <= req1_dir;
        op_sh   <= req1_sh;
      end
      if (state == ST_SHIFT) rsp_data <= shift_out;
      if (rsp_hs) begin
        ptr <= ~owner;
        if (done_cnt != {CNTW{1'b1}}) done_cnt <= done_cnt + 1'b1;
      end
    end
  end

  bsh_32 u_bsh_32 (
    .data_in  (op_data),
    .dir      (op_dir),
    .sh       (op_sh),
    .data_out (shift_out)
  );

endmodule

// File: tb/tb_bsh_arb.sv
module tb_bsh_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic        req0_dir, req1_dir;
  logic [4:0]  req0_sh, req1_sh;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_data;
  logic        busy;
  logic [15:0] done_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bsh_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_dir   (req0_dir),
    .req0_sh    (req0_sh),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_dir   (req1_dir),
    .req1_sh    (req1_sh),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req0_valid = 0; req1_valid = 0;
    req0_data = '0; req1_data = '0;
    req0_dir = 0; req1_dir = 0;
    req0_sh = '0; req1_sh = '0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic apply_reset;
    clear_inputs();
    rst_n = 0;
    #12;
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  // Issues one request on a port and collects the result; rsp_ready is
  // raised once the response appears. lat counts cycles from the request
  // handshake cycle to the first cycle with rspX_valid high.
  task automatic run_op(input int port, input logic [31:0] d, input logic dr,
                        input logic [4:0] s, output logic [31:0] got,
                        output int lat, output bit ok);
    int w;
    ok = 1; lat = 0; got = '0;
    if (port == 0) begin req0_valid = 1; req0_data = d; req0_dir = dr; req0_sh = s; end
    else           begin req1_valid = 1; req1_data = d; req1_dir = dr; req1_sh = s; end
    #1;
    w = 0;
    while (((port == 0) ? req0_ready : req1_ready) !== 1'b1 && w < 10) begin step(); w++; end
    if (w >= 10) ok = 0;
    step();
    req0_valid = 0; req1_valid = 0;
    lat = 1;
    while (((port == 0) ? rsp0_valid : rsp1_valid) !== 1'b1 && lat < 10) begin step(); lat++; end
    if (lat >= 10) ok = 0;
    got = rsp_data;
    if (port == 0) rsp0_ready = 1; else rsp1_ready = 1;
    step();
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    clear_inputs();
    #3;
    n_cmp++; if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}); end
    n_cmp++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    n_cmp++; if (done_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_single;
    req0_valid = 1; req0_data = 32'h18A00000; req0_dir = 0; req0_sh = 5'd10;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
    step();
    req0_valid = 0; req0_data = '0; req0_sh = '0;
    n_cmp++; if ({busy, rsp0_valid} !== 2'b10) begin
      n_fail++; $display("FAIL single_shift got=%b exp=10", {busy, rsp0_valid}); end
    step();
    n_cmp++; if (rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency got=%b exp=1", rsp0_valid); end
    n_cmp++; if (rsp_data !== 32'h80000000) begin n_fail++; $display("FAIL single_data got=%h exp=80000000", rsp_data); end
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    n_cmp++; if ({busy, rsp0_valid} !== 2'b00) begin n_fail++; $display("FAIL single_idle got=%b exp=00", {busy, rsp0_valid}); end
    n_cmp++; if (done_cnt !== 16'd1) begin n_fail++; $display("FAIL single_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_right_port1;
    bit saw0;
    int c;
    saw0 = 0;
    req1_valid = 1; req1_data = 32'h00FF0003; req1_dir = 1; req1_sh = 5'd20;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL p1_ready got=%b exp=01", {req0_ready, req1_ready}); end
    step();
    req1_valid = 0; req1_data = 32'hFFFFFFFF;  // live inputs must not affect the shift
    c = 0;
    while (rsp1_valid !== 1'b1 && c < 10) begin if (rsp0_valid) saw0 = 1; step(); c++; end
    if (rsp0_valid) saw0 = 1;
    n_cmp++; if (c !== 1) begin n_fail++; $display("FAIL p1_latency got=%0d exp=1", c); end
    n_cmp++; if (rsp_data !== 32'h0000000F) begin n_fail++; $display("FAIL p1_data got=%h exp=0000000f", rsp_data); end
    rsp0_ready = 1;   // non-owner ready must be ignored
    step();
    n_cmp++; if (rsp1_valid !== 1'b1) begin n_fail++; $display("FAIL p1_nonowner_ready got=%b exp=1", rsp1_valid); end
    rsp0_ready = 0; rsp1_ready = 1;
    step();
    rsp1_ready = 0;
    if (rsp0_valid) saw0 = 1;
    n_cmp++; if (saw0 !== 1'b0) begin n_fail++; $display("FAIL p1_rsp0_quiet got=%b exp=0", saw0); end
    n_cmp++; if (done_cnt !== 16'd2) begin n_fail++; $display("FAIL p1_done_cnt got=%0d exp=2", done_cnt); end
  endtask

  task automatic test_alternation;
    logic [31:0] exp_d [3];
    int          exp_p [3];
    apply_reset();
    exp_p[0] = 0; exp_d[0] = 32'h00000002;
    exp_p[1] = 1; exp_d[1] = 32'h00000010;
    exp_p[2] = 0; exp_d[2] = 32'h00000002;
    req0_valid = 1; req0_data = 32'h1;  req0_dir = 0; req0_sh = 5'd1;
    req1_valid = 1; req1_data = 32'h80; req1_dir = 1; req1_sh = 5'd3;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if ({req0_ready, req1_ready} !== ((exp_p[k] == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL alt_grant%0d got=%b exp_port=%0d", k, {req0_ready, req1_ready}, exp_p[k]); end
      step(); step();
      n_cmp++; if ({rsp0_valid, rsp1_valid} !== ((exp_p[k] == 0) ? 2'b10 : 2'b01) || rsp_data !== exp_d[k]) begin
        n_fail++; $display("FAIL alt_rsp%0d got=%b/%h exp_port=%0d data=%h", k, {rsp0_valid, rsp1_valid}, rsp_data, exp_p[k], exp_d[k]); end
      step();
    end
    clear_inputs();
    n_cmp++; if (done_cnt !== 16'd3) begin n_fail++; $display("FAIL alt_done_cnt got=%0d exp=3", done_cnt); end
  endtask

  task automatic test_backpressure;
    bit bad;
    bad = 0;
    req0_valid = 1; req0_data = 32'h0000F00D; req0_dir = 0; req0_sh = 5'd4;
    req1_valid = 1; req1_data = 32'h12345678; req1_dir = 0; req1_sh = 5'd0;
    #1;
    // pointer is at port 1 after the alternation test
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_grant_ptr got=%b exp=01", {req0_ready, req1_ready}); end
    req1_valid = 0;
    #1;
    step();
    req0_valid = 0;
    req1_valid = 1;
    step();
    for (int k = 0; k < 5; k++) begin
      if (rsp0_valid !== 1'b1 || rsp_data !== 32'h000F00D0 || req1_ready !== 1'b0 || busy !== 1'b1) bad = 1;
      step();
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL bp_hold got=%b/%h/%b/%b exp=1/000f00d0/0/1", rsp0_valid, rsp_data, req1_ready, busy); end
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    n_cmp++; if ({busy, rsp0_valid} !== 2'b00) begin n_fail++; $display("FAIL bp_release got=%b exp=00", {busy, rsp0_valid}); end
    n_cmp++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_next_grant got=%b exp=1", req1_ready); end
    req1_valid = 0;
    #1;
  endtask

  task automatic test_boundary;
    logic [31:0] got;
    int lat;
    bit ok;
    run_op(1, 32'hDEADBEEF, 1'b0, 5'd0, got, lat, ok);
    n_cmp++; if (!ok || got !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sh0 got=%h ok=%0d exp=deadbeef", got, ok); end
    run_op(0, 32'h00000001, 1'b0, 5'd31, got, lat, ok);
    n_cmp++; if (!ok || got !== 32'h80000000) begin n_fail++; $display("FAIL sh31_left got=%h ok=%0d exp=80000000", got, ok); end
    run_op(1, 32'hFFFFFFFF, 1'b1, 5'd31, got, lat, ok);
    n_cmp++; if (!ok || got !== 32'h00000001) begin n_fail++; $display("FAIL sh31_right got=%h ok=%0d exp=00000001", got, ok); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL op_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] got;
    int lat;
    bit ok, bad;
    bad = 0;
    req1_valid = 1; req1_data = 32'hAAAA5555; req1_dir = 0; req1_sh = 5'd1;
    #1;
    step();
    req1_valid = 0;
    req0_valid = 1;   // held valid: ready must still read 0 during reset
    rsp1_ready = 1;
    #2;
    rst_n = 0;
    #1;
    n_cmp++; if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0 || rsp_data !== 32'h0 || done_cnt !== 16'h0) begin
      n_fail++; $display("FAIL async_reset got=%b/%h/%0d exp=00000/0/0", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, rsp_data, done_cnt); end
    req0_valid = 0;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (rsp0_valid || rsp1_valid || busy) bad = 1;
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL abandoned_rsp got=1 exp=0"); end
    rsp1_ready = 0;
    req0_valid = 1; req1_valid = 1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL ptr_after_reset got=%b exp=10", {req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
    #1;
    run_op(0, 32'h0000000F, 1'b1, 5'd2, got, lat, ok);
    n_cmp++; if (!ok || got !== 32'h00000003 || lat !== 2) begin
      n_fail++; $display("FAIL post_reset_op got=%h lat=%0d ok=%0d exp=00000003 lat=2", got, lat, ok); end
    n_cmp++; if (done_cnt !== 16'd1) begin n_fail++; $display("FAIL post_reset_cnt got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_right_port1();
    test_alternation();
    test_backpressure();
    test_boundary();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
